tcdm_stream_master: RTL and testbench
=====================================

TCDM_STREAM_MASTER -- requirements
Module: tcdm_stream_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: read-data FIFO entries, which is also the outstanding-request limit (power of 2, >=2).
REQ-002 Parameter LEN_WIDTH, default 16: width of the word-count field.
REQ-003 Clock and reset are fixed as follows: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  clock; all state on rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 cfg_start_i  in  1  start pulse; sampled only in IDLE.
REQ-007 cfg_dir_i  in  1  0 = RX (stream to memory writes), 1 = TX (memory reads to stream).
REQ-008 cfg_addr_i  in  32  start byte address; bits [1:0] ignored.
REQ-009 cfg_len_i  in  LEN_WIDTH  transfer length in 32-bit words.
REQ-010 cfg_abort_i  in  1  stop issuing requests and finish early.
REQ-011 busy_o  out  1  high in any state other than IDLE.
REQ-012 done_o  out  1  one-cycle completion pulse.
REQ-013 words_left_o  out  LEN_WIDTH  requests not yet granted.
REQ-014 rx_data_i / rx_valid_i / rx_ready_o  in/in/out  32/1/1  inbound stream.
REQ-015 tx_data_o / tx_valid_o / tx_ready_i  out/out/in  32/1/1  outbound stream.
REQ-016 tcdm_req_o, tcdm_gnt_i, tcdm_add_o[31:0], tcdm_wen_o (1 = read), tcdm_be_o[3:0], tcdm_data_o[31:0], tcdm_r_data_i[31:0], tcdm_r_valid_i: single TCDM master port.

Function
REQ-017 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE to RUN on cfg_start_i=1 with cfg_len_i!=0:
- latch address {cfg_addr_i[31:2],2'b00}, length, and direction.
REQ-019 IDLE to DONE on cfg_start_i=1 with cfg_len_i=0: no TCDM request is issued.
REQ-020 RUN to DRAIN when words_left reaches 0 or cfg_abort_i=1.
REQ-021 DRAIN to DONE when outstanding=0 and, in TX, the FIFO is empty:
- on abort, remaining FIFO data is discarded in DRAIN (tx_valid_o=0).
REQ-022 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-023 A request fires when tcdm_req_o & tcdm_gnt_i. On each fire:
- address += 4, wrapping modulo 2^32;
- words_left decrements;
- outstanding increments.
REQ-024 Each tcdm_r_valid_i decrements outstanding. A simultaneous fire and response SHALL leave outstanding unchanged.
REQ-025 tcdm_req_o requires RUN, words_left>0, and outstanding<FIFO_DEPTH. In TX it additionally requires fifo_count+outstanding<FIFO_DEPTH.
REQ-026 RX mode:
- tcdm_req_o = conditions(REQ-025) & rx_valid_i;
- tcdm_wen_o=0, tcdm_data_o=rx_data_i;
- rx_ready_o = tcdm_req_o & tcdm_gnt_i (combinational);
- write responses are counted only.
REQ-027 TX mode:
- tcdm_wen_o=1, tcdm_data_o=0, rx_ready_o=0;
- tcdm_r_data_i is pushed into the FIFO on tcdm_r_valid_i;
- tx_valid_o = FIFO not empty; pop on tx_valid_o & tx_ready_i.
REQ-028 tcdm_be_o SHALL be 4'hF whenever tcdm_req_o=1.
REQ-029 Once tcdm_req_o is asserted, it and add/wen/data SHALL stay stable until granted, except on abort or reset.
REQ-030 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged. The FIFO SHALL never overflow; REQ-025 guarantees this.
REQ-031 Response latency is not fixed; any latency >=1 cycle SHALL be tolerated.
REQ-032 Responses arriving in IDLE SHALL be ignored.
REQ-033 cfg_start_i outside IDLE SHALL be ignored.
REQ-034 cfg_abort_i in IDLE or DONE SHALL be ignored.
REQ-035 Throughput: with gnt held at 1 and response latency 1, one request per cycle SHALL be sustained.

Reset
REQ-036 On rst_i=1, asynchronously:
- state=IDLE;
- all outputs 0 (busy_o, done_o, words_left_o, tcdm_*_o, rx_ready_o, tx_valid_o, tx_data_o);
- FIFO and outstanding counter cleared.
REQ-037 Reset mid-transfer SHALL abandon the transfer without a done_o pulse. Responses in flight at reset release SHALL be ignored.

Verification
REQ-038 RX, addr 0x1C000002, len 3, rx_valid always 1, gnt always 1 -> writes to 0x1C000000/04/08, be=F, done_o 1 cycle after last response.
REQ-039 TX, len 8, 30% random gnt stall, tx_ready toggling -> 8 stream words equal to memory contents in order; outstanding+FIFO never >4.
REQ-040 TX, tx_ready=0 throughout -> exactly 4 reads issued, then req_o stays 0; releasing tx_ready completes the remaining 4.
REQ-041 len 0 start -> no tcdm_req_o; done_o pulses 2 cycles after start.
REQ-042 RX addr 0xFFFFFFFC, len 2 -> addresses 0xFFFFFFFC, 0x00000000.
REQ-043 Abort after 2 grants of a len-10 TX, then reset asserted mid-DRAIN in a second run -> first run: done_o after draining, FIFO flushed; second run: all outputs 0, no done_o.

Source files
------------

// File: rtl/tcdm_stream_master.sv
// Streams words between a 32-bit valid/ready stream and a single TCDM master port.
// RX turns stream beats into memory writes, TX turns memory reads into stream beats.
module tcdm_stream_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_start_i,
  input  logic                 cfg_dir_i,
  input  logic [31:0]          cfg_addr_i,
  input  logic [LEN_WIDTH-1:0] cfg_len_i,
  input  logic                 cfg_abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_WIDTH-1:0] words_left_o,
  input  logic [31:0]          rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [31:0]          tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic [1:0]           dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t               state;
  logic                 dir;
  logic                 aborted;
  logic [31:0]          addr;
  logic [LEN_WIDTH-1:0] words_left;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        fifo_count;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [31:0]          fifo_mem [FIFO_DEPTH];

  logic          req_ok;
  logic          credit_ok;
  logic          fire;
  logic          resp;
  logic          push;
  logic          pop;
  logic          drain_done;
  logic [CW-1:0] out_next;
  logic [CW-1:0] count_next;

  // Handshakes: a transfer happens on any cycle where valid and ready are both
  // high (req & gnt on TCDM); a raised valid/req holds its payload until taken.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < {1'b0, DEPTH};
  assign req_ok    = (state == RUN) && (words_left != '0) && (outstanding < DEPTH) && !cfg_abort_i;
  assign tcdm_req_o = req_ok && (dir ? credit_ok : rx_valid_i);
  assign fire       = tcdm_req_o && tcdm_gnt_i;
  assign resp       = tcdm_r_valid_i && (state != IDLE) && (outstanding != '0);
  assign push       = resp && dir && !aborted;
  assign tx_valid_o = dir && !aborted && (fifo_count != '0) && ((state == RUN) || (state == DRAIN));
  assign pop        = tx_valid_o && tx_ready_i;

  assign tx_data_o    = tx_valid_o ? fifo_mem[rd_ptr] : 32'd0;
  assign rx_ready_o   = fire && !dir;
  assign tcdm_add_o   = addr;
  assign tcdm_wen_o   = dir && (state != IDLE);
  assign tcdm_be_o    = {4{tcdm_req_o}};
  assign tcdm_data_o  = (tcdm_req_o && !dir) ? rx_data_i : 32'd0;
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign words_left_o = words_left;
  assign dbg_state    = state;

  always_comb begin
    out_next = outstanding;
    if (fire && !resp)
      out_next = outstanding + CW'(1);
    else if (!fire && resp)
      out_next = outstanding - CW'(1);
    count_next = fifo_count;
    if (push && !pop)
      count_next = fifo_count + CW'(1);
    else if (!push && pop)
      count_next = fifo_count - CW'(1);
  end

  // An aborted TX discards its FIFO, so only the in-flight responses gate completion.
  assign drain_done = (out_next == '0) && (aborted || !dir || (count_next == '0));

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[wr_ptr] <= tcdm_r_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      dir         <= 1'b0;
      aborted     <= 1'b0;
      addr        <= 32'd0;
      words_left  <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= out_next;
      fifo_count  <= count_next;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (fire) begin
        addr       <= addr + 32'd4;
        words_left <= words_left - LEN_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          outstanding <= '0;
          fifo_count  <= '0;
          wr_ptr      <= '0;
          rd_ptr      <= '0;
          if (cfg_start_i) begin
            addr       <= {cfg_addr_i[31:2], 2'b00};
            words_left <= cfg_len_i;
            dir        <= cfg_dir_i;
            aborted    <= 1'b0;
            state      <= (cfg_len_i != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (cfg_abort_i) begin
            state      <= DRAIN;
            aborted    <= 1'b1;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
          end else if (fire && (words_left == LEN_WIDTH'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcdm_stream_master.sv
// Directed bench for tcdm_stream_master: a TCDM slave model with variable latency,
// stream drivers, and expected-value queues compared as the DUT produces output.
module tb_tcdm_stream_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_start_i, cfg_dir_i, cfg_abort_i;
  logic [31:0] cfg_addr_i;
  logic [15:0] cfg_len_i;
  logic        busy_o, done_o;
  logic [15:0] words_left_o;
  logic [31:0] rx_data_i;
  logic        rx_valid_i, rx_ready_o;
  logic [31:0] tx_data_o;
  logic        tx_valid_o, tx_ready_i;
  logic        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [3:0]  tcdm_be_o;
  logic [1:0]  dbg_state;

  tcdm_stream_master #(.FIFO_DEPTH(4), .LEN_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_start_i(cfg_start_i), .cfg_dir_i(cfg_dir_i),
    .cfg_addr_i(cfg_addr_i), .cfg_len_i(cfg_len_i), .cfg_abort_i(cfg_abort_i),
    .busy_o(busy_o), .done_o(done_o), .words_left_o(words_left_o),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- bookkeeping ----------------
  int tests = 0, fails = 0, cyc = 0;
  int fires, writes, resps, pops, done_cnt, req_seen, max_infl;
  int done_cyc, last_resp_cyc, first_fire_cyc, last_fire_cyc, start_cyc;
  int stall_pct = 0, lat_min = 1, lat_max = 1, tx_mode = 1, last_due = 0, rx_idx = 0;
  bit track_infl = 0, pend_prev = 0;
  logic [31:0] pend_add, rx_base;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [31:0] resp_q[$];
  int          due_q[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    fires = 0; writes = 0; resps = 0; pops = 0; done_cnt = 0; req_seen = 0; max_infl = 0;
    done_cyc = -1; last_resp_cyc = -1; first_fire_cyc = -1; last_fire_cyc = -1; rx_idx = 0;
  endtask

  // ---------------- monitor / scoreboard (samples pre-edge values) ----------------
  always @(posedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      if (tcdm_req_o) req_seen++;
      if (pend_prev && !cfg_abort_i) begin
        check("req_hold", {31'd0, tcdm_req_o}, 32'd1);
        check("add_hold", tcdm_add_o, pend_add);
      end
      pend_prev = tcdm_req_o && !tcdm_gnt_i;
      pend_add  = tcdm_add_o;
      if (tcdm_req_o && tcdm_gnt_i) begin
        fires++;
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
        last_fire_cyc = cyc;
        check("be", {28'd0, tcdm_be_o}, 32'h0000000F);
        if (exp_addr_q.size() > 0) check("addr", tcdm_add_o, exp_addr_q.pop_front());
        else check("addr_unexpected_fire", 32'd1, 32'd0);
        if (!tcdm_wen_o) begin
          writes++;
          mem[tcdm_add_o] = tcdm_data_o;
          if (exp_wdata_q.size() > 0) check("wdata", tcdm_data_o, exp_wdata_q.pop_front());
          else check("wdata_unexpected", 32'd1, 32'd0);
        end else begin
          resp_q.push_back(mem.exists(tcdm_add_o) ? mem[tcdm_add_o] : 32'd0);
        end
        begin
          int due;
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          due_q.push_back(due);
          if (!tcdm_wen_o) resp_q.push_back(32'd0);
        end
      end
      if (tcdm_r_valid_i) begin resps++; last_resp_cyc = cyc; end
      if (rx_valid_i && rx_ready_o) rx_idx++;
      if (tx_valid_o && tx_ready_i) begin
        pops++;
        if (exp_q.size() > 0) check("tx_data", tx_data_o, exp_q.pop_front());
        else check("tx_unexpected", 32'd1, 32'd0);
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (track_infl && (fires - pops) > max_infl) max_infl = fires - pops;
    end else begin
      pend_prev = 0;
    end
  end

  // ---------------- slave / stream drivers (change inputs away from the edge) ----------------
  always @(negedge clk_i) begin
    tcdm_gnt_i = ($urandom_range(99, 0) >= stall_pct);
    if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = resp_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      tcdm_r_valid_i = 1'b0;
      tcdm_r_data_i  = 32'd0;
    end
    if (tx_mode == 0) tx_ready_i = 1'b0;
    else if (tx_mode == 1) tx_ready_i = 1'b1;
    else tx_ready_i = ~tx_ready_i;
    rx_data_i = rx_base + 32'(rx_idx);
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic dir, input logic [31:0] addr, input logic [15:0] len);
    @(negedge clk_i);
    cfg_dir_i = dir; cfg_addr_i = addr; cfg_len_i = len; cfg_start_i = 1'b1;
    start_cyc = cyc;
    @(negedge clk_i);
    cfg_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done_cnt != d0}, 32'd1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic check_outputs_zero(input string p);
    check({p, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({p, "_done"}, {31'd0, done_o}, 32'd0);
    check({p, "_words_left"}, {16'd0, words_left_o}, 32'd0);
    check({p, "_req"}, {31'd0, tcdm_req_o}, 32'd0);
    check({p, "_add"}, tcdm_add_o, 32'd0);
    check({p, "_wen"}, {31'd0, tcdm_wen_o}, 32'd0);
    check({p, "_be"}, {28'd0, tcdm_be_o}, 32'd0);
    check({p, "_wdata"}, tcdm_data_o, 32'd0);
    check({p, "_rx_ready"}, {31'd0, rx_ready_o}, 32'd0);
    check({p, "_tx_valid"}, {31'd0, tx_valid_o}, 32'd0);
    check({p, "_tx_data"}, tx_data_o, 32'd0);
    check({p, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic load_tx(input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      mem[base + 32'(4 * i)] = $urandom;
      exp_q.push_back(mem[base + 32'(4 * i)]);
      exp_addr_q.push_back(base + 32'(4 * i));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_i = 1'b1; cfg_start_i = 0; cfg_dir_i = 0; cfg_abort_i = 0; cfg_addr_i = 0; cfg_len_i = 0;
    rx_valid_i = 0; rx_base = 32'hA5A50000; tx_ready_i = 1'b1;
    clear_stats();
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // RX: unaligned start, full-rate grants, latency 1
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(32'h1C000000 + 32'(4 * i));
      exp_wdata_q.push_back(rx_base + 32'(i));
    end
    rx_valid_i = 1'b1;
    start_xfer(1'b0, 32'h1C000002, 16'd3);
    check("rx_words_left_latched", {16'd0, words_left_o}, 32'd3);
    check("rx_busy", {31'd0, busy_o}, 32'd1);
    wait_done("rx", 40);
    rx_valid_i = 1'b0;
    check("rx_writes", writes, 3);
    check("rx_back_to_back", last_fire_cyc - first_fire_cyc, 2);
    check("rx_done_after_last_resp", done_cyc, last_resp_cyc + 1);
    check("rx_done_pulses", done_cnt, 1);
    check("rx_mem_word1", mem[32'h1C000004], rx_base + 32'd1);
    check("rx_words_left_end", {16'd0, words_left_o}, 32'd0);

    // TX: random grant stalls, variable latency, toggling tx_ready
    clear_stats();
    stall_pct = 30; lat_min = 1; lat_max = 3; tx_mode = 2; track_infl = 1;
    load_tx(32'h20000000, 8);
    start_xfer(1'b1, 32'h20000000, 16'd8);
    wait_done("tx_rand", 400);
    track_infl = 0;
    check("tx_rand_pops", pops, 8);
    check("tx_rand_exp_empty", exp_q.size(), 0);
    check("tx_rand_inflight_max_le4", {31'd0, max_infl <= 4}, 32'd1);
    check("tx_rand_done_pulses", done_cnt, 1);

    // TX with sink stalled: credit limit stops issue at FIFO depth
    clear_stats();
    stall_pct = 0; lat_min = 1; lat_max = 1; tx_mode = 0;
    load_tx(32'h30000000, 8);
    start_xfer(1'b1, 32'h30000000, 16'd8);
    repeat (20) @(negedge clk_i);
    check("tx_stall_fires", fires, 4);
    check("tx_stall_req_low", {31'd0, tcdm_req_o}, 32'd0);
    check("tx_stall_words_left", {16'd0, words_left_o}, 32'd4);
    tx_mode = 1;
    wait_done("tx_stall", 100);
    check("tx_stall_fires_total", fires, 8);
    check("tx_stall_pops", pops, 8);

    // zero-length start
    clear_stats();
    start_xfer(1'b0, 32'h00000100, 16'd0);
    wait_done("len0", 10);
    check("len0_latency_ok", {31'd0, (done_cyc - start_cyc - 1) >= 1 && (done_cyc - start_cyc - 1) <= 2}, 32'd1);
    check("len0_no_req", req_seen, 0);
    check("len0_done_pulses", done_cnt, 1);

    // RX address wrap at 2^32
    clear_stats();
    rx_base = 32'h5A5A0000;
    exp_addr_q.push_back(32'hFFFFFFFC); exp_addr_q.push_back(32'h00000000);
    exp_wdata_q.push_back(rx_base); exp_wdata_q.push_back(rx_base + 32'd1);
    rx_valid_i = 1'b1;
    start_xfer(1'b0, 32'hFFFFFFFC, 16'd2);
    wait_done("wrap", 40);
    rx_valid_i = 1'b0;
    check("wrap_writes", writes, 2);
    check("wrap_mem0", mem[32'h00000000], rx_base + 32'd1);

    // TX abort after two grants: drains responses, discards FIFO
    clear_stats();
    tx_mode = 0;
    load_tx(32'h40000000, 10);
    exp_q.delete();
    start_xfer(1'b1, 32'h40000000, 16'd10);
    begin
      int n = 0;
      while (fires < 2 && n < 50) begin @(negedge clk_i); n++; end
    end
    check("abort_two_fires", fires, 2);
    check("abort_fifo_had_data", {31'd0, tx_valid_o}, 32'd1);
    cfg_abort_i = 1'b1;
    @(negedge clk_i);
    cfg_abort_i = 1'b0;
    tx_mode = 1;
    wait_done("abort", 50);
    check("abort_fires_final", fires, 2);
    check("abort_no_stream_out", pops, 0);
    check("abort_done_pulses", done_cnt, 1);
    check("abort_busy_end", {31'd0, busy_o}, 32'd0);
    exp_addr_q.delete();

    // second run: reset while draining with responses still in flight
    clear_stats();
    tx_mode = 0; lat_min = 3; lat_max = 3;
    load_tx(32'h50000000, 10);
    exp_q.delete();
    start_xfer(1'b1, 32'h50000000, 16'd10);
    begin
      int n = 0;
      while (fires < 2 && n < 50) begin @(negedge clk_i); n++; end
    end
    cfg_abort_i = 1'b1;
    @(negedge clk_i);
    cfg_abort_i = 1'b0;
    check("rst_mid_state_drain", {30'd0, dbg_state}, 32'd2);
    #1 rst_i = 1'b1;
    #1 check_outputs_zero("rst_mid");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle_after", {31'd0, busy_o}, 32'd0);
    check("rst_mid_no_req", {31'd0, tcdm_req_o}, 32'd0);
    exp_addr_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
